// File: rtl/top_level.sv
// Half-precision float to signed 8.8 fixed-point converter. The operand is read
// from data memory bytes 5:4 and the result is written back to bytes 7:6.
module data_mem (
    input  logic        clk,
    input  logic [7:0]  raddr,
    output logic [15:0] rdata,
    input  logic        we,
    input  logic [7:0]  waddr,
    input  logic [15:0] wdata
);
    // Not reset: contents survive reset so software-placed operands stay put.
    logic [7:0] mem_core [0:255];

    assign rdata = {mem_core[raddr + 8'd1], mem_core[raddr]};

    always_ff @(posedge clk) begin
        if (we) begin
            mem_core[waddr]        <= wdata[7:0];
            mem_core[waddr + 8'd1] <= wdata[15:8];
        end
    end
endmodule

module top_level (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic ack
);
    localparam logic [7:0] OP_ADDR  = 8'd4;
    localparam logic [7:0] RES_ADDR = 8'd6;

    typedef enum logic [2:0] {IDLE, LOAD, CONVERT, STORE, DONE} state_t;

    state_t      state;
    logic [15:0] operand;
    logic [15:0] result;
    logic [15:0] rdata;
    logic [15:0] conv;
    logic [15:0] mant;
    logic [15:0] mag;
    logic [4:0]  expo;
    logic        we;

    assign we = (state == STORE);

    data_mem dm (
        .clk   (clk),
        .raddr (OP_ADDR),
        .rdata (rdata),
        .we    (we),
        .waddr (RES_ADDR),
        .wdata (result)
    );

    // Binary point sits 8 bits up, so the implicit one lands at bit 8 when
    // the unbiased exponent is 0, i.e. the mantissa shifts by (e - 17).
    always_comb begin
        expo = operand[14:10];
        mant = {5'd0, 1'b1, operand[9:0]};
        mag  = '0;
        conv = '0;
        if (expo == 5'd0) begin
            conv = '0;
        end else if (expo >= 5'd22) begin
            conv = operand[15] ? 16'h8000 : 16'h7FFF;
        end else begin
            if (expo >= 5'd17)
                mag = mant << (expo - 5'd17);
            else
                mag = mant >> (5'd17 - expo);
            conv = operand[15] ? (16'd0 - mag) : mag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ack     <= 1'b0;
            operand <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    operand <= rdata;
                    state   <= CONVERT;
                end
                CONVERT: begin
                    result <= conv;
                    state  <= STORE;
                end
                STORE: begin
                    state <= DONE;
                    ack   <= 1'b1;
                end
                DONE: begin
                    if (start) begin
                        ack   <= 1'b0;
                        state <= LOAD;
                    end
                end
                default: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_top_level.sv
// Directed bench for the fp16 -> 8.8 converter: table of operand/result pairs
// plus reset, ack-hold, restart and busy-start control checks.
module tb_top_level;
    logic clk = 1'b0;
    logic reset;
    logic start;
    logic ack;

    int n_assert = 0;
    int n_fail   = 0;

    top_level dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .ack   (ack)
    );

    always #5 clk = ~clk;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        while (ack !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check1(tag, ack, 1'b1);
    endtask

    task automatic load_op(input logic [15:0] op);
        dut.dm.mem_core[4] <= op[7:0];
        dut.dm.mem_core[5] <= op[15:8];
        @(negedge clk);
    endtask

    task automatic run_case(input logic [15:0] op, input logic [15:0] exp);
        reset = 1'b1;
        @(negedge clk);
        check1("ack_in_reset", ack, 1'b0);
        reset = 1'b0;
        load_op(op);
        check1("ack_idle", ack, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ack("ack_timeout");
        check16($sformatf("conv_%h", op), {dut.dm.mem_core[7], dut.dm.mem_core[6]}, exp);
    endtask

    logic [15:0] ops  [18];
    logic [15:0] exps [18];

    initial begin
        ops[0]  = 16'h3C00; exps[0]  = 16'h0100;
        ops[1]  = 16'h3E00; exps[1]  = 16'h0180;
        ops[2]  = 16'h4040; exps[2]  = 16'h0220;
        ops[3]  = 16'h4B00; exps[3]  = 16'h0E00;
        ops[4]  = 16'hBC00; exps[4]  = 16'hFF00;
        ops[5]  = 16'hC200; exps[5]  = 16'hFD00;
        ops[6]  = 16'hC040; exps[6]  = 16'hFDE0;
        ops[7]  = 16'hCB00; exps[7]  = 16'hF200;
        ops[8]  = 16'h0000; exps[8]  = 16'h0000;
        ops[9]  = 16'h8000; exps[9]  = 16'h0000;
        ops[10] = 16'h0001; exps[10] = 16'h0000;
        ops[11] = 16'h1C00; exps[11] = 16'h0001;
        ops[12] = 16'h1800; exps[12] = 16'h0000;
        ops[13] = 16'h6300; exps[13] = 16'h7FFF;
        ops[14] = 16'h7B80; exps[14] = 16'h7FFF;
        ops[15] = 16'hE300; exps[15] = 16'h8000;
        ops[16] = 16'h5800; exps[16] = 16'h7FFF;
        ops[17] = 16'hD800; exps[17] = 16'h8000;

        reset = 1'b1;
        start = 1'b0;
        dut.dm.mem_core[3] <= 8'hA5;
        dut.dm.mem_core[8] <= 8'h5A;
        #2;
        check1("ack_async_reset", ack, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check1("ack_idle_after_reset", ack, 1'b0);

        for (int i = 0; i < 18; i++) run_case(ops[i], exps[i]);

        // Neighbouring bytes and the operand must be untouched.
        check16("operand_preserved", {dut.dm.mem_core[5], dut.dm.mem_core[4]}, 16'hD800);
        check16("neighbours_preserved", {dut.dm.mem_core[8], dut.dm.mem_core[3]}, 16'h5AA5);

        // ack holds in DONE across idle cycles.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check1("ack_hold", ack, 1'b1);
        end

        // Restart from DONE: ack clears on the next edge, new result follows.
        load_op(16'h3E00);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check1("ack_clear_on_restart", ack, 1'b0);
        wait_ack("ack_timeout_restart");
        check16("restart_result", {dut.dm.mem_core[7], dut.dm.mem_core[6]}, 16'h0180);

        // Reset while in DONE drops ack without a clock edge.
        #2 reset = 1'b1;
        #1 check1("ack_async_drop", ack, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        check16("mem_kept_over_reset", {dut.dm.mem_core[7], dut.dm.mem_core[6]}, 16'h0180);

        // Reset mid-conversion aborts; the following start completes correctly.
        load_op(16'hC200);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check1("ack_mid_reset", ack, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check1("ack_stays_idle_after_abort", ack, 1'b0);
        load_op(16'h4B00);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ack("ack_timeout_after_abort");
        check16("result_after_abort", {dut.dm.mem_core[7], dut.dm.mem_core[6]}, 16'h0E00);

        // start held through the busy states is ignored; ack then stays up.
        load_op(16'hBC00);
        start = 1'b1;
        @(negedge clk);
        check1("ack_clear_busy_start", ack, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check1("ack_latency_busy_start", ack, 1'b1);
        check16("busy_start_result", {dut.dm.mem_core[7], dut.dm.mem_core[6]}, 16'hFF00);
        repeat (3) @(negedge clk);
        check1("ack_hold_after_busy_start", ack, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/top_level.md
TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Port clk, input, 1 bit: system clock; all state changes on its rising edge except reset.
REQ-003 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-004 Port start, input, 1 bit: request pulse, sampled on rising clk; high for one cycle begins a conversion.
REQ-005 Port ack, output, 1 bit: conversion complete; result valid in data memory.
REQ-006 The module SHALL contain a data memory instance named dm with a byte array mem_core[0:255] (8 bits per entry), directly readable and writable by hierarchical reference from a bench.

Function
REQ-007 Operand SHALL be an IEEE half-precision float read as {mem_core[5], mem_core[4]} (byte 5 = bits 15:8): s = bit 15, e = bits 14:10 (bias 15), f = bits 9:0.
REQ-008 Result SHALL be a signed two's-complement 8.8 fixed-point value written to {mem_core[7], mem_core[6]} (byte 7 = bits 15:8); no other memory bytes are modified.
REQ-009 e = 0 (zero or subnormal): result SHALL be 0x0000 for either sign.
REQ-010 e >= 22 (unbiased exponent >= 7, including Inf/NaN at e = 31): result SHALL saturate to 0x7FFF if s = 0, 0x8000 if s = 1.
REQ-011 1 <= e <= 21: magnitude SHALL be M = {1, f} (11 bits) shifted left by (e - 17) if e >= 17, else shifted right by (17 - e), discarding shifted-out bits (truncation toward zero, no rounding).
REQ-012 Sign SHALL be applied after truncation: result = s ? -M : M (16-bit two's complement); M = 0 with s = 1 gives 0x0000.
REQ-013 FSM states SHALL be IDLE, LOAD, CONVERT, STORE, DONE.
REQ-014 IDLE -> LOAD on rising clk with start = 1; LOAD reads both operand bytes; CONVERT performs classification, shift and negation (single- or multi-cycle); STORE writes both result bytes; STORE -> DONE.
REQ-015 ack SHALL be 0 in IDLE/LOAD/CONVERT/STORE and 1 in DONE; ack rises no later than 32 clk cycles after the start sample.
REQ-016 DONE SHALL hold ack = 1 until reset or a new start; start = 1 in DONE SHALL clear ack on the next clk edge and begin a new conversion (DONE -> LOAD).
REQ-017 start asserted while busy (LOAD/CONVERT/STORE) SHALL be ignored.
REQ-018 Result bytes SHALL be written no later than the edge on which ack rises, so both are valid whenever ack = 1.

Reset
REQ-019 reset = 1 SHALL immediately force state IDLE and ack = 0, independent of clk.
REQ-020 Reset SHALL NOT clear dm.mem_core; contents written before or during reset are preserved.
REQ-021 Reset mid-conversion SHALL abort it; result bytes may be unwritten, the FSM restarts in IDLE, and the next start performs a full conversion.
REQ-022 After reset deasserts, the block SHALL remain in IDLE (ack = 0) until start is sampled high.

Verification
REQ-023 Per case: assert reset 1 cycle, release, write operand to mem_core[5:4], pulse start 1 cycle, wait for ack, compare {mem_core[7], mem_core[6]}.
REQ-024 Positive normals: 0x3C00 -> 0x0100; 0x3E00 -> 0x0180; 0x4040 -> 0x0220; 0x4B00 -> 0x0E00.
REQ-025 Negatives: 0xBC00 -> 0xFF00; 0xC200 -> 0xFD00; 0xC040 -> 0xFDE0; 0xCB00 -> 0xF200.
REQ-026 Zero, subnormal and truncation: 0x0000 -> 0x0000; 0x8000 -> 0x0000; 0x0001 -> 0x0000; 0x1C00 -> 0x0001; 0x1800 -> 0x0000.
REQ-027 Saturation: 0x6300 -> 0x7FFF; 0x7B80 -> 0x7FFF; 0xE300 -> 0x8000; 0x5800 -> 0x7FFF; 0xD800 -> 0x8000.
REQ-028 Control: ack = 0 during and after reset; ack stays 1 for 10+ idle cycles after completion; reset asserted mid-conversion drops ack to 0 at once; a following start yields the correct result.
